// File: rtl/hazard_pkg.sv
// Shared types and helpers for the decode-stage hazard/stall controller.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [SEL_W-1:0] FWD_REG = 2'b00;
    localparam logic [SEL_W-1:0] FWD_EX  = 2'b01;
    localparam logic [SEL_W-1:0] FWD_MEM = 2'b10;

    // Forwarding source for one operand; EX wins over MEM, r0 never forwards.
    function automatic logic [SEL_W-1:0] fwd_select(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] ex_dest,
        input logic             ex_reg_write,
        input logic             ex_mem_read,
        input logic [REG_W-1:0] mem_dest,
        input logic             mem_reg_write
    );
        logic [SEL_W-1:0] sel;
        sel = FWD_REG;
        if (ex_reg_write && (ex_dest != '0) && (ex_dest == src) && !ex_mem_read) begin
            sel = FWD_EX;
        end else if (mem_reg_write && (mem_dest != '0) && (mem_dest == src)) begin
            sel = FWD_MEM;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_md_sequencer.sv
// Occupancy sequencer for the multi-cycle mult/div unit (IDLE/BUSY/DONE plus down-counter).
module md_sequencer
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    input  logic stall,
    output logic md_busy,
    output logic md_done
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // DONE behaves like IDLE for a new start so back-to-back operations issue without a gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE, MD_DONE: begin
                if (start && !stall) begin
                    state_d = MD_BUSY;
                    cnt_d   = div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
        busy_d = (state_d == MD_BUSY);
        done_d = (state_d == MD_DONE);
    end

    assign md_busy = busy_q;
    assign md_done = done_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Decode-stage hazard unit: load-use and HI/LO interlocks, operand forwarding, mult/div scheduling.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] dec_rs,
    input  logic [REG_W-1:0] dec_rt,
    input  logic             dec_uses_rs,
    input  logic             dec_uses_rt,
    input  logic             dec_reads_hilo,
    input  logic             dec_md_start,
    input  logic             dec_md_div,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_reg_write,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             id_bubble,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic             md_busy,
    output logic             md_done,
    output logic [31:0]      stall_count
);

    localparam int unsigned STALL_CNT_W = 32;

    logic                   load_use;
    logic                   md_hold;
    logic                   stall;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    always_comb begin
        load_use = ex_mem_read && (ex_dest != '0) &&
                   ((dec_uses_rs && (ex_dest == dec_rs)) ||
                    (dec_uses_rt && (ex_dest == dec_rt)));
        md_hold  = md_busy && (dec_reads_hilo || dec_md_start);
        stall    = load_use || md_hold;
    end

    // Pipeline controls are combinational; reset forces the free-running, no-forward values.
    always_comb begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        id_bubble = 1'b0;
        fwd_a_sel = FWD_REG;
        fwd_b_sel = FWD_REG;
        if (reset) begin
            fwd_a_sel = fwd_select(dec_rs, ex_dest, ex_reg_write, ex_mem_read,
                                   mem_dest, mem_reg_write);
            fwd_b_sel = fwd_select(dec_rt, ex_dest, ex_reg_write, ex_mem_read,
                                   mem_dest, mem_reg_write);
            if (stall) begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                id_bubble = 1'b1;
            end
        end
    end

    md_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_sequencer (
        .clk     (clk),
        .reset   (reset),
        .start   (dec_md_start),
        .div     (dec_md_div),
        .stall   (stall),
        .md_busy (md_busy),
        .md_done (md_done)
    );

    // Saturating count of frozen-PC cycles.
    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_en && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed plus randomized bench for hazard_stall_controller against a cycle-level reference model.
module tb_hazard_stall_controller;

    localparam int unsigned MULT_N = 4;
    localparam int unsigned DIV_N  = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  dec_rs, dec_rt, ex_dest, mem_dest;
    logic        dec_uses_rs, dec_uses_rt, dec_reads_hilo, dec_md_start, dec_md_div;
    logic        ex_reg_write, ex_mem_read, mem_reg_write;
    logic        pc_en, ifid_en, id_bubble, md_busy, md_done;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_count;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining busy cycles, pending done pulse, stall total.
    int          busy_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_stalls = 32'd0;

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dec_rs         (dec_rs),
        .dec_rt         (dec_rt),
        .dec_uses_rs    (dec_uses_rs),
        .dec_uses_rt    (dec_uses_rt),
        .dec_reads_hilo (dec_reads_hilo),
        .dec_md_start   (dec_md_start),
        .dec_md_div     (dec_md_div),
        .ex_dest        (ex_dest),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .mem_dest       (mem_dest),
        .mem_reg_write  (mem_reg_write),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .id_bubble      (id_bubble),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .md_busy        (md_busy),
        .md_done        (md_done),
        .stall_count    (stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (ex_reg_write && ex_dest != 5'd0 && ex_dest == src && !ex_mem_read) return 2'b01;
        if (mem_reg_write && mem_dest != 5'd0 && mem_dest == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        dec_rs = 5'd0; dec_rt = 5'd0; ex_dest = 5'd0; mem_dest = 5'd0;
        dec_uses_rs = 1'b0; dec_uses_rt = 1'b0; dec_reads_hilo = 1'b0;
        dec_md_start = 1'b0; dec_md_div = 1'b0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_reg_write = 1'b0;
    endtask

    // Check every output against the model, then clock once and advance the model.
    task automatic run_cycle();
        bit lu, hold, stl;
        logic [1:0] fa, fb;
        #1;
        lu   = ex_mem_read && ex_dest != 5'd0 &&
               ((dec_uses_rs && ex_dest == dec_rs) || (dec_uses_rt && ex_dest == dec_rt));
        hold = (busy_left > 0) && (dec_reads_hilo || dec_md_start);
        stl  = reset && (lu || hold);
        fa   = reset ? ref_fwd(dec_rs) : 2'b00;
        fb   = reset ? ref_fwd(dec_rt) : 2'b00;
        check("pc_en",       32'(pc_en),       32'(!stl));
        check("ifid_en",     32'(ifid_en),     32'(!stl));
        check("id_bubble",   32'(id_bubble),   32'(stl));
        check("fwd_a_sel",   32'(fwd_a_sel),   32'(fa));
        check("fwd_b_sel",   32'(fwd_b_sel),   32'(fb));
        check("md_busy",     32'(md_busy),     32'(busy_left > 0));
        check("md_done",     32'(md_done),     32'(m_done));
        check("stall_count", stall_count,      m_stalls);
        @(posedge clk);
        if (!reset) begin
            busy_left = 0;
            m_done    = 1'b0;
            m_stalls  = 32'd0;
        end else begin
            if (stl && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
            if (busy_left > 0) begin
                busy_left = busy_left - 1;
                m_done    = (busy_left == 0);
            end else if (dec_md_start && !stl) begin
                busy_left = dec_md_div ? DIV_N : MULT_N;
                m_done    = 1'b0;
            end else begin
                m_done = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        run_cycle();
        reset = 1'b1;
        #1;
        check("rst_stall_count", stall_count, 32'd0);
        check("rst_md_busy", 32'(md_busy), 32'd0);
        run_cycle();

        // Load-use: exactly one bubble cycle.
        ex_mem_read = 1'b1; ex_dest = 5'd8; dec_rs = 5'd8; dec_uses_rs = 1'b1;
        #1;
        check("t1_bubble", 32'(id_bubble), 32'd1);
        run_cycle();
        clear_inputs();
        #1;
        check("t1_count", stall_count, 32'd1);
        check("t1_released", 32'(pc_en), 32'd1);
        run_cycle();

        // Forwarding priority: EX over MEM, MEM once EX targets r0.
        ex_reg_write = 1'b1; ex_dest = 5'd5; mem_dest = 5'd5; mem_reg_write = 1'b1; dec_rt = 5'd5;
        #1;
        check("t2_fwd_ex", 32'(fwd_b_sel), 32'd1);
        run_cycle();
        ex_dest = 5'd0;
        #1;
        check("t2_fwd_mem", 32'(fwd_b_sel), 32'd2);
        run_cycle();
        clear_inputs();

        // MULT then MFHI held: 4 stalled busy cycles, released on md_done.
        dec_md_start = 1'b1;
        run_cycle();
        dec_md_start = 1'b0; dec_reads_hilo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_busy", 32'(md_busy), 32'd1);
            check("t3_stalled", 32'(pc_en), 32'd0);
            run_cycle();
        end
        #1;
        check("t3_done", 32'(md_done), 32'd1);
        check("t3_release", 32'(pc_en), 32'd1);
        run_cycle();
        clear_inputs();

        // DIV, then a second start held from three cycles later until accepted in DONE.
        dec_md_start = 1'b1; dec_md_div = 1'b1;
        run_cycle();
        clear_inputs();
        run_cycle();
        run_cycle();
        dec_md_start = 1'b1;
        n = 0;
        while (!md_done && n < 40) begin
            run_cycle();
            n++;
        end
        check("t4_done_seen", 32'(md_done), 32'd1);
        check("t4_accept_ok", 32'(pc_en), 32'd1);
        run_cycle();
        clear_inputs();
        #1;
        check("t4_rebusy", 32'(md_busy), 32'd1);
        repeat (6) run_cycle();

        // Reset while a divide is at counter 20.
        dec_md_start = 1'b1; dec_md_div = 1'b1;
        run_cycle();
        clear_inputs();
        repeat (11) run_cycle();
        reset = 1'b0;
        run_cycle();
        reset = 1'b1;
        #1;
        check("t5_busy_cleared", 32'(md_busy), 32'd0);
        check("t5_count_cleared", stall_count, 32'd0);
        repeat (40) run_cycle();

        // Start colliding with load-use is dropped, then accepted next cycle.
        ex_mem_read = 1'b1; ex_dest = 5'd3; dec_rt = 5'd3; dec_uses_rt = 1'b1; dec_md_start = 1'b1;
        run_cycle();
        #1;
        check("t6_not_started", 32'(md_busy), 32'd0);
        ex_mem_read = 1'b0;
        run_cycle();
        clear_inputs();
        #1;
        check("t6_started", 32'(md_busy), 32'd1);
        repeat (6) run_cycle();

        // Randomized traffic with a small register set to provoke hazards.
        repeat (3000) begin
            reset          = ($urandom_range(63, 0) != 0);
            dec_rs         = 5'($urandom_range(3, 0));
            dec_rt         = 5'($urandom_range(3, 0));
            ex_dest        = 5'($urandom_range(3, 0));
            mem_dest       = 5'($urandom_range(3, 0));
            dec_uses_rs    = 1'($urandom_range(1, 0));
            dec_uses_rt    = 1'($urandom_range(1, 0));
            dec_reads_hilo = ($urandom_range(3, 0) == 0);
            dec_md_start   = ($urandom_range(7, 0) == 0);
            dec_md_div     = ($urandom_range(3, 0) == 0);
            ex_reg_write   = 1'($urandom_range(1, 0));
            ex_mem_read    = ($urandom_range(3, 0) == 0);
            mem_reg_write  = 1'($urandom_range(1, 0));
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
